// File: rtl/pwm_dt_pkg.sv
// Shared types and constants for the dead-time gate driver.
package pwm_dt_pkg;

  localparam int unsigned DT_W_DEFAULT = 8;
  localparam int unsigned DT_MIN       = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOW_ON,
    DT_L2H,
    HIGH_ON,
    DT_H2L,
    FAULT
  } state_e;

endpackage

// File: rtl/pwm_dt_timer.sv
// Load/decrement down-counter; done_c flags the last counted cycle.
module pwm_dt_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done_c = (cnt <= W'(1));

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary half-bridge drive with dead time, enable gating and latched fault.
// Optional minimum on-time hold when PWM_DT_MIN_ON_EN is defined.
module pwm_deadtime
  import pwm_dt_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEFAULT
`ifdef PWM_DT_MIN_ON_EN
  ,
  parameter int unsigned MIN_ON = 3
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dead_time,
  input  logic            fault_in,
  input  logic            fault_clr,
  output logic            pwm_h,
  output logic            pwm_l,
  output logic            fault_latched,
  output logic            in_deadtime
);

  state_e          state;
  state_e          state_nx;
  logic            pwm_q;
  logic            dt_load_c;
  logic            dt_done_c;
  logic            min_ok_c;
  logic [DT_W-1:0] dt_load_val_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_in;
    end
  end

  // Dead time is sampled only when a dead-time state is entered.
  assign dt_load_val_c = (dead_time < DT_W'(DT_MIN)) ? DT_W'(DT_MIN) : dead_time;
  assign dt_load_c     = (state_nx != state) && ((state_nx == DT_L2H) || (state_nx == DT_H2L));

  pwm_dt_timer #(.W(DT_W)) u_dt_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (dt_load_c),
    .load_val (dt_load_val_c),
    .done_c   (dt_done_c)
  );

`ifdef PWM_DT_MIN_ON_EN
  logic min_load_c;

  assign min_load_c = (state_nx != state) && ((state_nx == LOW_ON) || (state_nx == HIGH_ON));

  pwm_dt_timer #(.W(DT_W)) u_min_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (min_load_c),
    .load_val (DT_W'(MIN_ON)),
    .done_c   (min_ok_c)
  );
`else
  assign min_ok_c = 1'b1;
`endif

  // Next state: fault beats enable beats normal switching.
  always_comb begin
    state_nx = state;
    if (fault_in) begin
      state_nx = FAULT;
    end else if (state == FAULT) begin
      if (fault_clr) state_nx = IDLE;
    end else if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = pwm_q ? DT_L2H : DT_H2L;
        LOW_ON:  if (pwm_q && min_ok_c) state_nx = DT_L2H;
        DT_L2H: begin
          if (!pwm_q)         state_nx = LOW_ON;
          else if (dt_done_c) state_nx = HIGH_ON;
        end
        HIGH_ON: if (!pwm_q && min_ok_c) state_nx = DT_H2L;
        DT_H2L: begin
          if (pwm_q)          state_nx = HIGH_ON;
          else if (dt_done_c) state_nx = LOW_ON;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pwm_h         <= 1'b0;
      pwm_l         <= 1'b0;
      fault_latched <= 1'b0;
      in_deadtime   <= 1'b0;
    end else begin
      state         <= state_nx;
      pwm_h         <= (state_nx == HIGH_ON);
      pwm_l         <= (state_nx == LOW_ON);
      fault_latched <= (state_nx == FAULT);
      in_deadtime   <= (state_nx == DT_L2H) || (state_nx == DT_H2L);
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: vector table, directed corner sequences, random run vs drive-level model.
module tb_pwm_deadtime;

  localparam int unsigned DT_W = 8;
`ifdef PWM_DT_MIN_ON_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            pwm_in;
  logic [DT_W-1:0] dead_time;
  logic            fault_in;
  logic            fault_clr;
  logic            pwm_h;
  logic            pwm_l;
  logic            fault_latched;
  logic            in_deadtime;

  int checks = 0;
  int errors = 0;

  pwm_deadtime #(.DT_W(DT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pwm_in        (pwm_in),
    .dead_time     (dead_time),
    .fault_in      (fault_in),
    .fault_clr     (fault_clr),
    .pwm_h         (pwm_h),
    .pwm_l         (pwm_l),
    .fault_latched (fault_latched),
    .in_deadtime   (in_deadtime)
  );

  always #5 clk = ~clk;

  // Drive-level model: which side is on (0 none, 1 low, 2 high), which side we are heading to,
  // how many off cycles remain, and how long the current side must still be held.
  int m_drive, m_target, m_wait, m_hold;
  bit m_armed, m_flt, m_pq;

  function automatic int side_of(bit p);
    return p ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_drive = 0; m_target = 0; m_wait = 0; m_hold = 0;
    m_armed = 0; m_flt = 0; m_pq = 0;
  endtask

  task automatic start_gap(int dtv);
    m_drive  = 0;
    m_target = side_of(m_pq);
    m_wait   = dtv;
  endtask

  task automatic model_step();
    int dtv;
    dtv = (dead_time == '0) ? 1 : int'(dead_time);
    if (fault_in) begin
      m_flt = 1; m_armed = 0; m_drive = 0;
    end else if (m_flt) begin
      if (fault_clr) m_flt = 0;
    end else if (!enable) begin
      m_armed = 0; m_drive = 0;
    end else if (!m_armed) begin
      m_armed = 1;
      start_gap(dtv);
    end else if (m_drive != 0) begin
      if (m_hold > 1) m_hold--;
      else if (m_drive != side_of(m_pq)) start_gap(dtv);
    end else if (side_of(m_pq) != m_target) begin
      m_drive = side_of(m_pq); m_hold = HOLD;
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        m_drive = m_target; m_hold = HOLD;
      end
    end
    m_pq = pwm_in;
  endtask

  function automatic logic [3:0] model_exp();
    return {m_drive == 2, m_drive == 1, m_flt, m_armed && !m_flt && (m_drive == 0)};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    checks++;
    if (pwm_h & pwm_l) begin
      errors++;
      $display("FAIL overlap at %0t: pwm_h=%b pwm_l=%b required never both 1", $time, pwm_h, pwm_l);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] exp);
    checks++;
    if ({pwm_h, pwm_l, fault_latched, in_deadtime} !== exp) begin
      errors++;
      $display("FAIL %s at %0t: {h,l,flt,dt} got %b required %b", name, $time,
               {pwm_h, pwm_l, fault_latched, in_deadtime}, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; pwm_in = 1'b0; fault_in = 1'b0; fault_clr = 1'b0;
    dead_time = DT_W'(4);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Both-low cycles from a pwm_in change until the new side turns on; -1 if it never does.
  task automatic measure_gap(input logic new_pin, output int gap);
    bit reached;
    gap = 0; reached = 0;
    pwm_in = new_pin;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      if (new_pin ? pwm_h : pwm_l) reached = 1;
      else if (!pwm_h && !pwm_l) gap++;
    end
    if (!reached) gap = -1;
  endtask

  typedef struct {
    logic            en;
    logic            pin;
    logic [DT_W-1:0] dt;
    logic            flt;
    logic            clr;
    logic [3:0]      exp;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gap, cnt;
    bit saw_h;

    // {en, pin, dt, fault_in, fault_clr, expected {h,l,flt,dt}}
    tbl[0]  = '{1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 4'b0001};
    tbl[1]  = '{1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 4'b0001};
    tbl[2]  = '{1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 4'b0100};
    tbl[3]  = '{1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 4'b0100};
    tbl[4]  = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 4'b0100};
    tbl[5]  = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 4'b0001};
    tbl[6]  = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 4'b0001};
    tbl[7]  = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 4'b1000};
    tbl[8]  = '{1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 4'b0010};
    tbl[9]  = '{1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 4'b0000};
    tbl[10] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0001};
    tbl[11] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0100};
    tbl[12] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0000};
    tbl[13] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 4'b0010};
    tbl[14] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 4'b0010};
    tbl[15] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 4'b0010};
    tbl[16] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 4'b0000};

    do_reset();
    check4("reset_state", 4'b0000);
    for (int i = 0; i < NV; i++) begin
      enable = tbl[i].en; pwm_in = tbl[i].pin; dead_time = tbl[i].dt;
      fault_in = tbl[i].flt; fault_clr = tbl[i].clr;
      tick();
      check4($sformatf("vec%0d", i), tbl[i].exp);
    end
    fault_in = 1'b0; fault_clr = 1'b0;

    // First turn-on after enable waits the full dead time.
    do_reset();
    enable = 1'b1;
    cnt = 0; saw_h = 0;
    for (int i = 0; i < 20 && !pwm_l; i++) begin
      tick();
      if (in_deadtime) cnt++;
      if (pwm_h) saw_h = 1;
    end
    check_int("startup_dead_cycles", cnt, 4);
    check_int("startup_low_on", int'(pwm_l), 1);
    check_int("startup_no_high", int'(saw_h), 0);

    repeat (5) tick();
    measure_gap(1'b1, gap);
    check_int("gap_l2h_dt4", gap, 4);
    repeat (15) tick();
    measure_gap(1'b0, gap);
    check_int("gap_h2l_dt4", gap, 4);

    repeat (5) tick();
    dead_time = '0;
    measure_gap(1'b1, gap);
    check_int("gap_l2h_dt0", gap, 1);
    repeat (5) tick();
    measure_gap(1'b0, gap);
    check_int("gap_h2l_dt0", gap, 1);

    // Two-cycle glitch shorter than the dead time: high side must never turn on.
    repeat (5) tick();
    dead_time = DT_W'(5);
    pwm_in = 1'b1;
    cnt = 0; saw_h = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) pwm_in = 1'b0;
      tick();
      if (!pwm_l) cnt++;
      if (pwm_h) saw_h = 1;
    end
    check_int("glitch_low_off_cycles", cnt, 2);
    check_int("glitch_no_high", int'(saw_h), 0);
    check_int("glitch_low_restored", int'(pwm_l), 1);

    // Fault latch, clear rules, and restart through dead time.
    dead_time = DT_W'(2);
    measure_gap(1'b1, gap);
    check_int("gap_l2h_dt2", gap, 2);
    repeat (4) tick();
    fault_in = 1'b1; tick(); fault_in = 1'b0;
    check4("fault_hit", 4'b0010);
    tick();
    check4("fault_hold", 4'b0010);
    fault_in = 1'b1; fault_clr = 1'b1; tick(); fault_in = 1'b0; fault_clr = 1'b0;
    check4("fault_clr_blocked", 4'b0010);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check4("fault_cleared_idle", 4'b0000);
    tick();
    check4("restart_dt_a", 4'b0001);
    tick();
    check4("restart_dt_b", 4'b0001);
    tick();
    check4("restart_high", 4'b1000);

    // One-cycle low pulse right after HIGH_ON entry.
    pwm_in = 1'b0; tick(); pwm_in = 1'b1;
    check4("minon_e1", 4'b1000);
    tick();
`ifdef PWM_DT_MIN_ON_EN
    check4("minon_e2_held", 4'b1000);
`else
    check4("minon_e2_deadtime", 4'b0001);
`endif
    tick();
    check4("minon_e3", 4'b1000);

    // Asynchronous reset between edges clears outputs immediately.
    #2;
    reset = 1'b0;
    #1;
    check4("async_reset", 4'b0000);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 6) == 0) pwm_in = ~pwm_in;
      if ($urandom_range(0, 49) == 0) dead_time = DT_W'($urandom_range(0, 6));
      fault_in  = ($urandom_range(0, 199) == 0);
      fault_clr = ($urandom_range(0, 19) == 0);
      tick();
      check4("random", model_exp());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Downstream stage of the sine PWM generator.
- Takes its single-ended PWM bit and produces complementary high-side and low-side gate drives for a half-bridge.
- Inserts a programmable dead time between the two drives.
- Provides enable gating and a latched fault shutdown, so the sine PWM can drive a power stage without shoot-through.

Parameters:
- DT_W, 8, width of dead_time input and internal dead-time counter.
- MIN_ON, 3, minimum on-time in clk cycles; used only when PWM_DT_MIN_ON_EN is defined.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  1 = bridge may switch; 0 = both drives off.
- pwm_in  input  1  PWM bit from the sine generator, same clock domain.
- dead_time  input  DT_W  dead time in clk cycles; 0 is treated as 1.
- fault_in  input  1  active-high fault request (overcurrent etc.).
- fault_clr  input  1  single-cycle pulse that clears a latched fault.
- pwm_h  output  1  high-side gate drive.
- pwm_l  output  1  low-side gate drive.
- fault_latched  output  1  1 while in FAULT.
- in_deadtime  output  1  1 while in either dead-time state.

Behaviour:
- Reset (reset=0, async): state=IDLE; pwm_h=0, pwm_l=0, fault_latched=0, in_deadtime=0; counter=0; pwm_q=0.
- pwm_in is registered once into pwm_q. All decisions use pwm_q. All outputs are registered, decoded from next state.
- Invariant: pwm_h & pwm_l is never 1, in any state or transition.
- States and transitions (priority: fault > enable > normal):
  - IDLE: both off. When enable=1, go to DT_L2H if pwm_q=1, else DT_H2L. The counter loads on entry, so the first turn-on after enable also waits dead time.
  - LOW_ON: pwm_l=1. When pwm_q=1, go to DT_L2H and load the counter.
  - DT_L2H: both off. Counter decrements each cycle. At counter==1 with pwm_q=1, go to HIGH_ON. If pwm_q returns to 0 before then, go directly to LOW_ON; the high side never turned on, so there is no shoot-through risk.
  - HIGH_ON: pwm_h=1. When pwm_q=0, go to DT_H2L.
  - DT_H2L: mirror of DT_L2H. At counter==1 with pwm_q=0, go to LOW_ON. If pwm_q returns to 1 first, go back to HIGH_ON.
  - FAULT: both off, fault_latched=1.
- Counter load value is max(dead_time,1), sampled on entry to a dead-time state. A change to dead_time mid-count is ignored until the next entry.
- Timing: off-overlap equals exactly the loaded count. Example, dead_time=4:
  - pwm_in rises before edge T.
  - pwm_l falls after edge T+1.
  - pwm_h rises after edge T+5.
  - Both low for 4 cycles.
- enable=0 in any non-FAULT state: next state IDLE, both off on the next edge.
- fault_in=1 in any state: next state FAULT. It overrides enable and a simultaneous fault_clr.
- FAULT exits to IDLE only when fault_clr=1 and fault_in=0 in the same cycle. fault_clr at any other time is ignored.
- Reset asserted mid-operation forces the reset values immediately; no dead-time sequencing.

Optional Feature:
- Macro: PWM_DT_MIN_ON_EN.
- Defined:
  - Once HIGH_ON or LOW_ON is entered, the state holds at least MIN_ON cycles, even if pwm_q toggles. Uses a second counter.
  - A pwm_q change arriving earlier is acted on when the minimum expires, if still present.
  - Fault and enable=0 override the hold.
- Undefined: no minimum-on hold; behaviour exactly as above.

Decomposition:
- Shared package pwm_dt_pkg holds:
  - state enum (IDLE, LOW_ON, DT_L2H, HIGH_ON, DT_H2L, FAULT);
  - default DT_W;
  - localparam for the minimum dead-time clamp (1).
- One sub-module is natural: pwm_dt_timer, a load/decrement down-counter with done flag. It is instanced once for dead time, and a second time for min-on when PWM_DT_MIN_ON_EN is defined.

Test Plan:
- Reset release, enable=1, pwm_in=0, dead_time=4 -> pwm_l rises after 4 off cycles; pwm_h stays 0.
- dead_time=4, pwm_in 0->1 then back 1->0 after 20 cycles -> each transition shows exactly 4 cycles with both low; pwm_h&pwm_l never 1.
- dead_time=0 -> behaves as 1: a single cycle with both low at each transition.
- pwm_in glitch high for 2 cycles with dead_time=5 -> pwm_h never rises; pwm_l returns to 1 the cycle after pwm_q falls.
- fault_in pulse while HIGH_ON -> both off next edge, fault_latched=1. fault_clr with fault_in=1 -> stays latched. fault_clr with fault_in=0 -> IDLE, then a dead-time sequence follows.
- With PWM_DT_MIN_ON_EN and MIN_ON=3, pwm_in 1-cycle low pulse while HIGH_ON -> pwm_h held at least 3 cycles. Without the macro -> a dead-time sequence begins immediately.
